weight_pingpong_ctrl: RTL and testbench

Sequencer for a processing element's double-buffered weight path. It streams incoming weights into two SRAM banks through the weight demux in ping-pong order and drains the full bank through the weight mux into the multiply-accumulate pipeline. It generates accumulator-clear, MAC-enable and per-neuron output-valid strobes, and raises `done` after the last neuron. It sits between the weight source and the PE datapath, replacing ad-hoc bank sequencing.

---
 rtl/weight_pingpong_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_weight_pingpong_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong weight bank sequencer: fills two SRAM banks alternately from the
// weight source and drains each full bank into the MAC pipeline, one neuron per bank.
module weight_pingpong_ctrl #(
    parameter int N       = 16,
    parameter int DEPTH   = 16,
    parameter int NEURONS = 4,
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_valid,
    output logic       w_ready,
    output logic       demux_sel,
    output logic       wr_en1,
    output logic       wr_en2,
    output logic [7:0] write_addr1,
    output logic [7:0] write_addr2,
    output logic       mux_sel,
    output logic       rd_en1,
    output logic       rd_en2,
    output logic [7:0] read_addr1,
    output logic [7:0] read_addr2,
    output logic       acc_clr,
    output logic       mac_en,
    output logic       out_valid,
    output logic       done
);

    localparam int TOTAL = NEURONS * DEPTH;
    localparam int TOT_W = $clog2(TOTAL + 1);
    localparam int NRN_W = $clog2(NEURONS + 1);
    localparam int FL_W  = $clog2(MAC_LAT + 1);

    localparam logic [7:0]       LAST_IDX    = 8'(DEPTH - 1);
    localparam logic [TOT_W-1:0] TOTAL_WORDS = TOT_W'(TOTAL);
    localparam logic [NRN_W-1:0] LAST_NEURON = NRN_W'(NEURONS - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST  = FL_W'(MAC_LAT);
    localparam logic [FL_W-1:0]  FLUSH_PRE   = FL_W'(MAC_LAT - 1);
    // An out-of-range configuration never accepts weights, so it stays inert.
    localparam bit CFG_OK = (N >= 1) && (DEPTH >= 2) && (DEPTH <= 256) &&
                            (NEURONS >= 1) && (MAC_LAT >= 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Fill-side state
    logic [7:0]       wcnt_q, wcnt_d;
    logic [TOT_W-1:0] wtotal_q, wtotal_d;
    logic             demux_q, demux_d;
    logic [7:0]       wa1_q, wa1_d;
    logic [7:0]       wa2_q, wa2_d;
    logic [1:0]       bank_full_q, bank_full_d;

    // Drain-side state
    state_t           state_q;
    logic [7:0]       rcnt_q;
    logic [FL_W-1:0]  fcnt_q;
    logic [NRN_W-1:0] ncnt_q;
    logic             mux_q;
    logic             rd1_q, rd2_q;
    logic [7:0]       ra1_q, ra2_q;
    logic             clr_q, mac_q, ov_q, done_q;

    logic       w_ready_s, accept_s, fill_last_s, drain_last_s;
    logic [1:0] set_mask_s, clr_mask_s;

    assign w_ready_s    = CFG_OK && !rst && !done_q && !bank_full_q[demux_q] &&
                          (wtotal_q < TOTAL_WORDS);
    assign accept_s     = w_valid && w_ready_s;
    assign fill_last_s  = accept_s && (wcnt_q == LAST_IDX);
    assign drain_last_s = (state_q == ST_READ) && (rcnt_q == LAST_IDX);
    // A bank is only set while empty and only cleared while full, so the masks never collide.
    assign set_mask_s   = {fill_last_s & demux_q, fill_last_s & ~demux_q};
    assign clr_mask_s   = {drain_last_s & mux_q, drain_last_s & ~mux_q};

    // Fill-side next state: word counters, bank selection and held write addresses.
    always_comb begin
        wcnt_d      = wcnt_q;
        wtotal_d    = wtotal_q;
        demux_d     = demux_q;
        wa1_d       = wa1_q;
        wa2_d       = wa2_q;
        bank_full_d = (bank_full_q | set_mask_s) & ~clr_mask_s;
        if (accept_s) begin
            wtotal_d = wtotal_q + TOT_W'(1);
            if (demux_q) begin
                wa2_d = wcnt_q;
            end else begin
                wa1_d = wcnt_q;
            end
            if (wcnt_q == LAST_IDX) begin
                wcnt_d  = 8'd0;
                demux_d = !demux_q;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end else begin
            wcnt_d   = wcnt_q;
            wtotal_d = wtotal_q;
        end
    end

    // Fill-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= 8'd0;
            wtotal_q    <= '0;
            demux_q     <= 1'b0;
            wa1_q       <= 8'd0;
            wa2_q       <= 8'd0;
            bank_full_q <= 2'b00;
        end else begin
            wcnt_q      <= wcnt_d;
            wtotal_q    <= wtotal_d;
            demux_q     <= demux_d;
            wa1_q       <= wa1_d;
            wa2_q       <= wa2_d;
            bank_full_q <= bank_full_d;
        end
    end

    // Drain FSM with registered read strobes, addresses and neuron strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= 8'd0;
            fcnt_q  <= '0;
            ncnt_q  <= '0;
            mux_q   <= 1'b0;
            rd1_q   <= 1'b0;
            rd2_q   <= 1'b0;
            ra1_q   <= 8'd0;
            ra2_q   <= 8'd0;
            clr_q   <= 1'b0;
            mac_q   <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mac_q <= rd1_q | rd2_q;
            case (state_q)
                ST_IDLE: begin
                    ov_q <= 1'b0;
                    if (bank_full_q[mux_q]) begin
                        state_q <= ST_READ;
                        rcnt_q  <= 8'd0;
                        clr_q   <= 1'b1;
                        rd1_q   <= !mux_q;
                        rd2_q   <= mux_q;
                        if (mux_q) begin
                            ra2_q <= 8'd0;
                        end else begin
                            ra1_q <= 8'd0;
                        end
                    end
                end
                ST_READ: begin
                    clr_q <= 1'b0;
                    if (rcnt_q == LAST_IDX) begin
                        state_q <= ST_FLUSH;
                        fcnt_q  <= '0;
                        rd1_q   <= 1'b0;
                        rd2_q   <= 1'b0;
                        mux_q   <= !mux_q;
                    end else begin
                        rcnt_q <= rcnt_q + 8'd1;
                        if (mux_q) begin
                            ra2_q <= rcnt_q + 8'd1;
                        end else begin
                            ra1_q <= rcnt_q + 8'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // out_valid is raised one cycle early so it lands on the last flush cycle.
                    if (fcnt_q == FLUSH_LAST) begin
                        ov_q   <= 1'b0;
                        ncnt_q <= ncnt_q + NRN_W'(1);
                        if (ncnt_q == LAST_NEURON) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        fcnt_q <= fcnt_q + FL_W'(1);
                        ov_q   <= (fcnt_q == FLUSH_PRE);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    ov_q   <= 1'b0;
                    clr_q  <= 1'b0;
                    rd1_q  <= 1'b0;
                    rd2_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ready     = w_ready_s;
    assign demux_sel   = demux_q;
    assign wr_en1      = accept_s && !demux_q;
    assign wr_en2      = accept_s && demux_q;
    assign write_addr1 = wa1_d;
    assign write_addr2 = wa2_d;
    assign mux_sel     = mux_q;
    assign rd_en1      = rd1_q;
    assign rd_en2      = rd2_q;
    assign read_addr1  = ra1_q;
    assign read_addr2  = ra2_q;
    assign acc_clr     = clr_q;
    assign mac_en      = mac_q;
    assign out_valid   = ov_q;
    assign done        = done_q;

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Bench for weight_pingpong_ctrl: two instances (2 and 3 neurons) share stimulus and are
// compared every cycle against a schedule-based reference of fill/drain timing.
module tb_weight_pingpong_ctrl;

    localparam int DP = 4;
    localparam int ML = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, w_valid;
    logic       w_ready_s [2], demux_s [2], wr1_s [2], wr2_s [2], mux_s [2];
    logic       rd1_s [2], rd2_s [2], clr_s [2], mac_s [2], ov_s [2], done_s [2];
    logic [7:0] wa1_s [2], wa2_s [2], ra1_s [2], ra2_s [2];

    weight_pingpong_ctrl #(.N(16), .DEPTH(DP), .NEURONS(2), .MAC_LAT(ML)) u_dut2 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_s[0]),
        .demux_sel(demux_s[0]), .wr_en1(wr1_s[0]), .wr_en2(wr2_s[0]),
        .write_addr1(wa1_s[0]), .write_addr2(wa2_s[0]), .mux_sel(mux_s[0]),
        .rd_en1(rd1_s[0]), .rd_en2(rd2_s[0]), .read_addr1(ra1_s[0]), .read_addr2(ra2_s[0]),
        .acc_clr(clr_s[0]), .mac_en(mac_s[0]), .out_valid(ov_s[0]), .done(done_s[0])
    );

    weight_pingpong_ctrl #(.N(16), .DEPTH(DP), .NEURONS(3), .MAC_LAT(ML)) u_dut3 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_s[1]),
        .demux_sel(demux_s[1]), .wr_en1(wr1_s[1]), .wr_en2(wr2_s[1]),
        .write_addr1(wa1_s[1]), .write_addr2(wa2_s[1]), .mux_sel(mux_s[1]),
        .rd_en1(rd1_s[1]), .rd_en2(rd2_s[1]), .read_addr1(ra1_s[1]), .read_addr2(ra2_s[1]),
        .acc_clr(clr_s[1]), .mac_en(mac_s[1]), .out_valid(ov_s[1]), .done(done_s[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nn [2];
    int wtot [2];
    int rc [2][4];
    int wal [2][2];
    int first_ov [2];
    int first_done [2];

    task automatic chk(input int u, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL inst%0d %s cycle %0d: observed %0d expected %0d", u, tag, cyc, obs, exp);
        end
    endtask

    // Reference: each completed fill j schedules its READ start rc[u][j] from the
    // flag-visible cycle and the cycle the drain side returns to idle.
    task automatic cycle_inst(input int u);
        int k, b, r, kk, idle, f, mcnt;
        int wa_e [2];
        int ra_e [2];
        logic wr_e, acc_e, clr_e, mac_e, ov_e, done_e;
        logic rd_e [2];
        k = wtot[u] / DP;
        b = k % 2;
        done_e = (k == nn[u]) && (cyc >= rc[u][nn[u]-1] + DP + ML + 1);
        wr_e = !rst && !done_e && (k < nn[u]);
        if (k >= 2 && k < nn[u]) begin
            if (cyc < rc[u][k-2] + DP) wr_e = 1'b0;
        end
        acc_e = wr_e && w_valid;
        wa_e[0] = wal[u][0];
        wa_e[1] = wal[u][1];
        if (acc_e) wa_e[b] = wtot[u] % DP;
        rd_e[0] = 1'b0; rd_e[1] = 1'b0; ra_e[0] = 0; ra_e[1] = 0;
        clr_e = 1'b0; mac_e = 1'b0; ov_e = 1'b0; mcnt = 0;
        for (int j = 0; j < k; j++) begin
            r = rc[u][j];
            if (cyc >= r + DP) begin
                mcnt++;
                ra_e[j%2] = DP - 1;
            end
            if (cyc >= r && cyc < r + DP) begin
                rd_e[j%2] = 1'b1;
                ra_e[j%2] = cyc - r;
                clr_e = (cyc == r);
            end
            if (cyc > r && cyc <= r + DP) mac_e = 1'b1;
            if (cyc == r + DP + ML) ov_e = 1'b1;
        end
        chk(u, "w_ready", w_ready_s[u], wr_e);
        chk(u, "wr_en1", wr1_s[u], acc_e && b == 0);
        chk(u, "wr_en2", wr2_s[u], acc_e && b == 1);
        chk(u, "write_addr1", wa1_s[u], wa_e[0]);
        chk(u, "write_addr2", wa2_s[u], wa_e[1]);
        chk(u, "demux_sel", demux_s[u], b);
        chk(u, "mux_sel", mux_s[u], mcnt % 2);
        chk(u, "rd_en1", rd1_s[u], rd_e[0]);
        chk(u, "rd_en2", rd2_s[u], rd_e[1]);
        chk(u, "read_addr1", ra1_s[u], ra_e[0]);
        chk(u, "read_addr2", ra2_s[u], ra_e[1]);
        chk(u, "acc_clr", clr_s[u], clr_e);
        chk(u, "mac_en", mac_s[u], mac_e);
        chk(u, "out_valid", ov_s[u], ov_e);
        chk(u, "done", done_s[u], done_e);
        if (!rst && ov_s[u] === 1'b1 && first_ov[u] < 0) first_ov[u] = cyc;
        if (!rst && done_s[u] === 1'b1 && first_done[u] < 0) first_done[u] = cyc;
        if (rst) begin
            wtot[u] = 0;
            wal[u][0] = 0;
            wal[u][1] = 0;
        end else if (acc_e) begin
            wal[u][b] = wtot[u] % DP;
            wtot[u]++;
            if (wtot[u] % DP == 0) begin
                kk = wtot[u] / DP - 1;
                idle = (kk == 0) ? 0 : rc[u][kk-1] + DP + ML + 1;
                f = cyc + 1;
                rc[u][kk] = ((idle > f) ? idle : f) + 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic rs);
        w_valid = v;
        rst = rs;
        @(negedge clk);
        for (int u = 0; u < 2; u++) cycle_inst(u);
        if (rs) cyc = 0;
        else cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        for (int u = 0; u < 2; u++) begin
            first_ov[u] = -1;
            first_done[u] = -1;
        end
    endtask

    initial begin
        nn[0] = 2;
        nn[1] = 3;
        for (int u = 0; u < 2; u++) begin
            wtot[u] = 0;
            wal[u][0] = 0;
            wal[u][1] = 0;
            for (int j = 0; j < 4; j++) rc[u][j] = 0;
        end
        clear_marks();
        rst = 1'b1;
        w_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then a continuous stream (back-pressure and post-done too).
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        clear_marks();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk(0, "first_out_valid_cycle", first_ov[0], 11);
        chk(1, "first_out_valid_cycle", first_ov[1], 11);
        chk(0, "done_rise_cycle", first_done[0], 20);
        chk(1, "done_rise_cycle", first_done[1], 28);
        chk(0, "done_sticky", done_s[0], 1'b1);

        // Gapped source: valid every other cycle.
        step(1'b0, 1'b1);
        for (int i = 0; i < 44; i++) step((i % 2) == 0, 1'b0);

        // Reset in the second READ cycle, then a fresh 4-word stream.
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0);

        // Random source activity with occasional resets.
        step(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 65, $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
